shift_sequencer: RTL and testbench



---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_step.sv | 16 +
 rtl/shift_sequencer.sv | 85 ++++++++
 tb/tb_shift_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: direction codes,
// single-step limits and the sequencer state encoding.
package shift_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int STEP_MAX = 7;
  localparam int STEP_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result channels of the shift sequencer; the producer/consumer side
// uses the master modport, the sequencer itself uses slave.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amount;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amount, in_dir, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amount, in_dir, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_step.sv
// Combinational single-step logical shifter, 0..7 bits in either direction,
// zero fill on both sides.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]  data,
  input  logic [STEP_W-1:0] amount,
  input  logic              dir,
  output logic [WIDTH-1:0]  result
);

  assign result = (dir == DIR_RIGHT) ? (data >> amount) : (data << amount);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: splits a wide shift amount into steps of at
// most STEP_MAX bits, one registered step per cycle.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input logic              clk,
  input logic              rst,
  shift_sequencer_if.slave bus
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  shifted;
  logic [AMT_W-1:0]  remaining_q, remaining_d;
  logic [AMT_W-1:0]  remaining_after;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] step;

  // Never step past what is left, so the counter cannot underflow.
  assign step = (remaining_q > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX)
                                                 : remaining_q[STEP_W-1:0];
  assign remaining_after = remaining_q - AMT_W'(step);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data   (data_q),
    .amount (step),
    .dir    (dir_q),
    .result (shifted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      dir_q       <= DIR_LEFT;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d      = bus.in_data;
          remaining_d = bus.in_amount;
          dir_d       = bus.in_dir;
          state_d     = (bus.in_amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d      = shifted;
        remaining_d = remaining_after;
        if (remaining_after == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is masked by rst so nothing is offered while reset is held.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected words and latencies are
// queued when a request is driven and popped when the result appears.
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int WIDTH = 16;
  localparam int AMT_W = 5;
  localparam int WAIT_LIMIT = 20;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Bit-at-a-time reference, deliberately unlike the RTL's 7-bit chunking.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d,
                                             input logic [AMT_W-1:0] a,
                                             input logic dir);
    logic [WIDTH-1:0] r;
    r = d;
    for (int i = 0; i < int'(a); i++) r = (dir == DIR_RIGHT) ? (r >> 1) : (r << 1);
    return r;
  endfunction

  function automatic exp_t make_exp(input logic [WIDTH-1:0] d,
                                    input logic [AMT_W-1:0] a,
                                    input logic dir);
    exp_t e;
    e.data = model(d, a, dir);
    e.lat  = (int'(a) + 6) / 7;
    return e;
  endfunction

  // Called #1 after an edge; returns after the accept edge (+#1) and then
  // scrambles the inputs so late changes would show up as wrong results.
  task automatic send(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                      input logic dir, output bit ok);
    bus.in_data   = d;
    bus.in_amount = a;
    bus.in_dir    = dir;
    bus.in_valid  = 1'b1;
    sb_q.push_back(make_exp(d, a, dir));
    ok = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    bus.in_dir   = ~dir;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    while (!bus.out_valid && cyc < WAIT_LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ok = bus.out_valid;
  endtask

  task automatic handshake;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amount = '0;
    bus.in_dir    = DIR_LEFT;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_data got %h want 0000", bus.out_data); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got %b want 1", bus.in_ready); end
  endtask

  // Runs a table of requests with immediate consumption, checking latency and data.
  task automatic test_table(input string name, input logic [WIDTH-1:0] d[],
                            input logic [AMT_W-1:0] a[], input logic dir[]);
    exp_t e;
    int   cyc;
    bit   ok;
    for (int i = 0; i < d.size(); i++) begin
      send(d[i], a[i], dir[i], ok);
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL %s[%0d]_accept got no accept want accept", name, i); end
      wait_valid(cyc, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || cyc != e.lat) begin
        errors++;
        $display("[TB] FAIL %s[%0d]_latency got %0d (valid %b) want %0d", name, i, cyc, ok, e.lat);
      end
      checks++;
      if (bus.out_data !== e.data) begin
        errors++;
        $display("[TB] FAIL %s[%0d]_data got %h want %h", name, i, bus.out_data, e.data);
      end
      handshake;
    end
  endtask

  task automatic test_basic_shifts;
    test_table("basic", '{16'h0001, 16'h8000}, '{5'd9, 5'd15}, '{DIR_LEFT, DIR_RIGHT});
  endtask

  task automatic test_zero_amount;
    test_table("zero", '{16'hABCD, 16'hABCD}, '{5'd0, 5'd0}, '{DIR_LEFT, DIR_RIGHT});
  endtask

  task automatic test_max_amount;
    test_table("max", '{16'hFFFF, 16'hFFFF}, '{5'd31, 5'd31}, '{DIR_LEFT, DIR_RIGHT});
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   cyc;
    bit   ok;
    send(16'h00F0, 5'd4, DIR_RIGHT, ok);
    wait_valid(cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_first_valid got 0 want 1"); end
    e = sb_q.pop_front();
    bus.in_data   = 16'h0003;
    bus.in_amount = 5'd2;
    bus.in_dir    = DIR_LEFT;
    bus.in_valid  = 1'b1;
    sb_q.push_back(make_exp(16'h0003, 5'd2, DIR_LEFT));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold%0d_valid got %b want 1", i, bus.out_valid); end
      checks++;
      if (bus.out_data !== e.data) begin errors++; $display("[TB] FAIL bp_hold%0d_data got %h want %h", i, bus.out_data, e.data); end
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d_in_ready got %b want 0", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    handshake;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_idle_in_ready got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hFFFF;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_second_accept in_ready got %b want 0", bus.in_ready); end
    wait_valid(cyc, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || cyc != e.lat) begin errors++; $display("[TB] FAIL bp_second_latency got %0d want %0d", cyc, e.lat); end
    checks++;
    if (bus.out_data !== e.data) begin errors++; $display("[TB] FAIL bp_second_data got %h want %h", bus.out_data, e.data); end
    handshake;
  endtask

  task automatic test_reset_mid_shift;
    exp_t e;
    int   cyc;
    bit   ok;
    send(16'h1234, 5'd20, DIR_LEFT, ok);
    @(posedge clk);
    #2;
    rst = 1'b1;
    void'(sb_q.pop_back());
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_out_data got %h want 0000", bus.out_data); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_release got ready %b valid %b want ready 1 valid 0", bus.in_ready, bus.out_valid);
    end
    test_table("after_rst", '{16'h0003}, '{5'd1}, '{DIR_LEFT});
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] d[];
    logic [AMT_W-1:0] a[];
    logic             dir[];
    d   = new[8];
    a   = new[8];
    dir = new[8];
    for (int i = 0; i < 8; i++) begin
      d[i]   = WIDTH'($urandom);
      a[i]   = AMT_W'($urandom_range(0, 31));
      dir[i] = 1'($urandom_range(0, 1));
    end
    test_table("b2b", d, a, dir);
  endtask

  initial begin
    test_reset();
    test_basic_shifts();
    test_zero_amount();
    test_max_amount();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
